// File: rtl/decode_issue_block.sv
// Decode/issue stage: splits instructions, reads the 8x16 register file with write-back bypass, stalls on busy registers.
// Latency 1 cycle from accept to out_valid; instr_ready drops combinationally on a RAW/WAW hazard, no downstream backpressure.
// Reset (active-low, async) clears registers, busy bits and the issued bundle.
module decode_issue_block #(
    parameter int NREG = 8,
    parameter int DW   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   instr_in,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic          wb_en,
    input  logic [2:0]    wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          out_valid,
    output logic [5:0]    op_dec,
    output logic [DW-1:0] A,
    output logic [DW-1:0] B,
    output logic [DW-1:0] data_in,
    output logic [2:0]    rd_ex
);

    logic [DW-1:0]   r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic            r_out_valid;
    logic [5:0]      r_op_dec;
    logic [DW-1:0]   r_a;
    logic [DW-1:0]   r_b;
    logic [DW-1:0]   r_data_in;
    logic [2:0]      r_rd_ex;

    logic [5:0]      w_op;
    logic [2:0]      w_rd;
    logic [2:0]      w_rs;
    logic [2:0]      w_rt;
    logic            w_is_nop;
    logic            w_is_rfmt;
    logic [NREG-1:0] w_busy_eff;
    logic            w_hazard;
    logic            w_accept;
    logic            w_wb_live;
    logic [DW-1:0]   w_rs_val;
    logic [DW-1:0]   w_rt_val;
    logic [DW-1:0]   w_rd_val;
    logic [DW-1:0]   w_imm;
    logic [5:0]      w_op_dec;

    assign w_op      = instr_in[15:10];
    assign w_rd      = instr_in[9:7];
    assign w_rs      = instr_in[6:4];
    assign w_rt      = instr_in[3:1];
    assign w_is_nop  = (w_op == 6'd0);
    assign w_is_rfmt = ~w_op[5];
    assign w_imm     = {{(DW-4){instr_in[3]}}, instr_in[3:0]};
    assign w_op_dec  = w_is_rfmt ? w_op : {1'b0, w_op[4:0]};
    assign w_wb_live = wb_en && (wb_addr != 3'd0);

    // A write-back landing this cycle releases its register immediately.
    always_comb begin
        w_busy_eff = '0;
        for (int i = 0; i < NREG; i++) begin
            w_busy_eff[i] = r_busy[i] & ~(wb_en && (wb_addr == 3'(i)));
        end
    end

    assign w_hazard = ~w_is_nop &
                      (w_busy_eff[w_rs] | (w_is_rfmt & w_busy_eff[w_rt]) | w_busy_eff[w_rd]);
    assign instr_ready = ~w_hazard;
    assign w_accept    = instr_valid & ~w_hazard;

    // Operand reads see the write-back value in the same cycle; R0 is hardwired to zero.
    assign w_rs_val = (w_rs == 3'd0) ? '0 :
                      (w_wb_live && wb_addr == w_rs) ? wb_data : r_regs[w_rs];
    assign w_rt_val = (w_rt == 3'd0) ? '0 :
                      (w_wb_live && wb_addr == w_rt) ? wb_data : r_regs[w_rt];
    assign w_rd_val = (w_rd == 3'd0) ? '0 :
                      (w_wb_live && wb_addr == w_rd) ? wb_data : r_regs[w_rd];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_live) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Clear before set so a new writer to the just-retired rd keeps it busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (w_accept && !w_is_nop && w_rd == 3'(i)) begin
                    r_busy[i] <= 1'b1;
                end else if (wb_en && wb_addr == 3'(i)) begin
                    r_busy[i] <= 1'b0;
                end
            end
            r_busy[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_op_dec    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_data_in   <= '0;
            r_rd_ex     <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_op_dec    <= w_op_dec;
            r_a         <= w_rs_val;
            r_b         <= w_is_rfmt ? w_rt_val : w_imm;
            r_data_in   <= w_rd_val;
            r_rd_ex     <= w_rd;
        end else begin
            r_out_valid <= 1'b0;
            r_op_dec    <= '0;
        end
    end

    assign out_valid = r_out_valid;
    assign op_dec    = r_op_dec;
    assign A         = r_a;
    assign B         = r_b;
    assign data_in   = r_data_in;
    assign rd_ex     = r_rd_ex;

endmodule

// File: tb/tb_decode_issue_block.sv
// Randomized self-checking bench for decode_issue_block against an array-based reference model.
module tb_decode_issue_block;

    logic        clk;
    logic        reset;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic [5:0]  op_dec;
    logic [15:0] A;
    logic [15:0] B;
    logic [15:0] data_in;
    logic [2:0]  rd_ex;

    decode_issue_block dut (
        .clk(clk), .reset(reset),
        .instr_in(instr_in), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .op_dec(op_dec), .A(A), .B(B),
        .data_in(data_in), .rd_ex(rd_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: register values, in-flight destinations, expected outputs.
    int  m_regs [8];
    bit  m_busy [8];
    int  e_valid, e_op, e_a, e_b, e_d, e_rd;
    int  last_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = 0;
            m_busy[i] = 0;
        end
        e_valid = 0; e_op = 0; e_a = 0; e_b = 0; e_d = 0; e_rd = 0;
    endtask

    function automatic int reg_read(input int idx);
        if (idx == 0) return 0;
        if (wb_en && int'(wb_addr) == idx) return int'(wb_data);
        return m_regs[idx];
    endfunction

    function automatic bit still_busy(input int idx);
        return m_busy[idx] && !(wb_en && int'(wb_addr) == idx);
    endfunction

    // Apply current inputs for one clock and compare ready before and outputs after the edge.
    task automatic step();
        int op, rd, rs, rt, lo, imm;
        bit nop, rfmt, hz, acc;
        int n_valid, n_op, n_a, n_b, n_d, n_rd;
        #1;
        op   = int'(instr_in[15:10]);
        rd   = int'(instr_in[9:7]);
        rs   = int'(instr_in[6:4]);
        rt   = int'(instr_in[3:1]);
        lo   = int'(instr_in[3:0]);
        nop  = (op == 0);
        rfmt = (op < 32);
        hz   = !nop && (still_busy(rs) || (rfmt && still_busy(rt)) || still_busy(rd));
        chk("instr_ready", 32'(instr_ready), 32'(!hz));
        last_ready = int'(!hz);
        acc = instr_valid && !hz;
        imm = (lo >= 8) ? lo - 16 : lo;
        n_valid = e_valid; n_op = e_op; n_a = e_a; n_b = e_b; n_d = e_d; n_rd = e_rd;
        if (acc) begin
            n_valid = 1;
            n_op    = rfmt ? op : op - 32;
            n_a     = reg_read(rs);
            n_b     = rfmt ? reg_read(rt) : (imm & 16'hFFFF);
            n_d     = reg_read(rd);
            n_rd    = rd;
        end else begin
            n_valid = 0;
            n_op    = 0;
        end
        @(posedge clk);
        if (wb_en && wb_addr != 3'd0) begin
            m_regs[wb_addr] = int'(wb_data);
        end
        if (wb_en) m_busy[wb_addr] = 0;
        if (acc && !nop && rd != 0) m_busy[rd] = 1;
        e_valid = n_valid; e_op = n_op; e_a = n_a; e_b = n_b; e_d = n_d; e_rd = n_rd;
        #1;
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("op_dec", 32'(op_dec), 32'(e_op));
        chk("A", 32'(A), 32'(e_a));
        chk("B", 32'(B), 32'(e_b));
        chk("data_in", 32'(data_in), 32'(e_d));
        chk("rd_ex", 32'(rd_ex), 32'(e_rd));
    endtask

    function automatic logic [15:0] mk_r(input int op, input int rd, input int rs, input int rt);
        return {6'(op), 3'(rd), 3'(rs), 3'(rt), 1'b0};
    endfunction

    function automatic logic [15:0] mk_i(input int op, input int rd, input int rs, input int lo);
        return {6'(op), 3'(rd), 3'(rs), 4'(lo)};
    endfunction

    initial begin
        reset = 1'b0; instr_in = '0; instr_valid = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        model_reset();
        last_ready = 0;

        // Reset release, idle.
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_op_dec", 32'(op_dec), 32'd0);
        chk("rst_ready_nop", 32'(instr_ready), 32'd1);
        step();

        // Write-back R1, R2, then R-type issue.
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h4000; step();
        wb_addr = 3'd2; wb_data = 16'hC000; step();
        wb_en = 1'b0;
        instr_in = mk_r(1, 3, 1, 2); instr_valid = 1'b1; step();
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_op", 32'(op_dec), 32'd1);
        chk("t2_A", 32'(A), 32'h4000);
        chk("t2_B", 32'(B), 32'hC000);
        chk("t2_rd", 32'(rd_ex), 32'd3);

        // RAW stall on R3 until its write-back, then bypassed operand.
        instr_in = mk_r(2, 4, 3, 0);
        step();
        chk("t3_stall_ready", 32'(last_ready), 32'd0);
        chk("t3_bubble", 32'(op_dec), 32'd0);
        step();
        chk("t3_stall2_ready", 32'(last_ready), 32'd0);
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h0008; step();
        chk("t3_wb_ready", 32'(last_ready), 32'd1);
        chk("t3_bypass_A", 32'(A), 32'h0008);
        wb_en = 1'b0;

        // Immediate sign extension.
        instr_in = mk_i(6'b100101, 5, 1, 4'b1000); step();
        chk("t4_op", 32'(op_dec), 32'd5);
        chk("t4_B", 32'(B), 32'hFFF8);
        chk("t4_A", 32'(A), 32'h4000);

        // R0: write ignored, never busy.
        instr_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'h1234; step();
        wb_en = 1'b0;
        instr_valid = 1'b1; instr_in = mk_r(3, 0, 1, 1); step();
        instr_in = mk_r(1, 6, 0, 0); step();
        chk("t5_ready", 32'(last_ready), 32'd1);
        chk("t5_A", 32'(A), 32'd0);

        // Async reset while stalled on R4.
        instr_in = mk_r(1, 7, 4, 0); step();
        chk("t6_stalled", 32'(last_ready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_op", 32'(op_dec), 32'd0);
        chk("t6_A", 32'(A), 32'd0);
        chk("t6_B", 32'(B), 32'd0);
        chk("t6_data", 32'(data_in), 32'd0);
        chk("t6_rd", 32'(rd_ex), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        step();
        chk("t6_ready_after", 32'(last_ready), 32'd1);

        // Randomized traffic with write-backs retiring in-flight destinations.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int op, pick;
            op = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 63));
            instr_in    = {6'(op), 10'($urandom)};
            instr_valid = ($urandom_range(0, 3) != 0);
            wb_en = 1'b0; wb_addr = '0; wb_data = 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                pick = -1;
                for (int t = 0; t < 8 && pick < 0; t++) begin
                    int c;
                    c = int'($urandom_range(0, 7));
                    if (m_busy[c]) pick = c;
                end
                if (pick >= 0) begin
                    wb_en = 1'b1; wb_addr = 3'(pick);
                end
            end else if ($urandom_range(0, 9) == 0) begin
                wb_en = 1'b1; wb_addr = 3'($urandom_range(0, 7));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
